// File: rtl/multicycle_chunk_adder_pkg.sv
// Shared definitions for the multi-cycle chunked adder: FSM state type and
// the ceiling-log2 helper used to size the chunk counter.
package multicycle_chunk_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/multicycle_chunk_adder_if.sv
// Operand/result handshake bundle for multicycle_chunk_adder.
interface multicycle_chunk_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/multicycle_chunk_adder_slice.sv
// CHUNK-wide ripple slice built from 1-bit full adders; also exposes the
// carry into its MSB so the top can derive signed overflow.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module chunk_ripple_adder #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);
  logic [W:0] w_c;

  assign w_c[0] = cin;

  for (genvar g = 0; g < W; g++) begin : g_fa
    full_adder u_fa (
      .a   (a[g]),
      .b   (b[g]),
      .cin (w_c[g]),
      .sum (sum[g]),
      .cout(w_c[g+1])
    );
  end

  assign cout     = w_c[W];
  assign c_msb_in = w_c[W-1];
endmodule

// File: rtl/multicycle_chunk_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock through one
// ripple slice, carrying between cycles, with valid/ready on both sides.
module multicycle_chunk_adder
  import multicycle_chunk_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_chunk_adder_if.slave bus
);
  localparam int unsigned NCH = WIDTH / CHUNK;
  localparam int unsigned CW  = (NCH > 1) ? clog2(NCH) : 1;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_last;
  logic [CHUNK-1:0] w_slice_sum;
  logic             w_slice_cout;
  logic             w_slice_cmsb;
  logic [WIDTH-1:0] w_slice_ext;
  logic [WIDTH-1:0] w_acc_next;

  chunk_ripple_adder #(.W(CHUNK)) u_slice (
    .a       (r_a[CHUNK-1:0]),
    .b       (r_b[CHUNK-1:0]),
    .cin     (r_carry),
    .sum     (w_slice_sum),
    .cout    (w_slice_cout),
    .c_msb_in(w_slice_cmsb)
  );

  assign w_last      = (r_cnt == CW'(NCH - 1));
  assign w_slice_ext = WIDTH'(w_slice_sum);
  // Shift-based fill stays legal when CHUNK == WIDTH (no zero-width slices).
  assign w_acc_next  = (r_acc >> CHUNK) | (w_slice_ext << (WIDTH - CHUNK));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // r_acc gathers slices during RUN; visible results (r_sum/r_cout/r_ovf)
  // update only on the edge into DONE so they hold through IDLE and RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && bus.in_valid) begin
        r_a     <= bus.a;
        r_b     <= bus.sub ? ~bus.b : bus.b;
        r_carry <= bus.sub | bus.cin;
        r_cnt   <= '0;
      end else if (r_state == ST_RUN) begin
        r_a     <= r_a >> CHUNK;
        r_b     <= r_b >> CHUNK;
        r_carry <= w_slice_cout;
        r_acc   <= w_acc_next;
        if (w_last) begin
          r_sum  <= w_acc_next;
          r_cout <= w_slice_cout;
          r_ovf  <= w_slice_cmsb ^ w_slice_cout;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_multicycle_chunk_adder.sv
// Bench for multicycle_chunk_adder: three instances (CHUNK = 4, 16, 1) driven
// with directed and random operations, checked against an arithmetic model.
module tb_multicycle_chunk_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] r_a = '0;
  logic [15:0] r_b = '0;
  logic        r_cin = 1'b0;
  logic        r_sub = 1'b0;
  logic [2:0]  r_in_valid = '0;
  logic [2:0]  r_out_ready = '0;

  logic [2:0]  w_in_ready;
  logic [2:0]  w_out_valid;
  logic [15:0] w_sum [3];
  logic [2:0]  w_cout;
  logic [2:0]  w_ovf;

  int          nch [3] = '{4, 1, 16};
  logic [15:0] prev_sum [3] = '{16'h0, 16'h0, 16'h0};

  int n_total = 0;
  int n_bad   = 0;

  multicycle_chunk_adder_if #(.WIDTH(16)) if0 ();
  multicycle_chunk_adder_if #(.WIDTH(16)) if1 ();
  multicycle_chunk_adder_if #(.WIDTH(16)) if2 ();

  multicycle_chunk_adder #(.WIDTH(16), .CHUNK(4))  u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  multicycle_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  multicycle_chunk_adder #(.WIDTH(16), .CHUNK(1))  u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.a = r_a;  assign if0.b = r_b;  assign if0.cin = r_cin;  assign if0.sub = r_sub;
  assign if1.a = r_a;  assign if1.b = r_b;  assign if1.cin = r_cin;  assign if1.sub = r_sub;
  assign if2.a = r_a;  assign if2.b = r_b;  assign if2.cin = r_cin;  assign if2.sub = r_sub;
  assign if0.in_valid = r_in_valid[0];  assign if0.out_ready = r_out_ready[0];
  assign if1.in_valid = r_in_valid[1];  assign if1.out_ready = r_out_ready[1];
  assign if2.in_valid = r_in_valid[2];  assign if2.out_ready = r_out_ready[2];

  assign w_in_ready  = {if2.in_ready,  if1.in_ready,  if0.in_ready};
  assign w_out_valid = {if2.out_valid, if1.out_valid, if0.out_valid};
  assign w_cout      = {if2.cout,      if1.cout,      if0.cout};
  assign w_ovf       = {if2.overflow,  if1.overflow,  if0.overflow};
  assign w_sum[0] = if0.sum;
  assign w_sum[1] = if1.sum;
  assign w_sum[2] = if2.sum;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [15:0] xa, input logic [15:0] xb, input logic xcin,
                       input logic xsub, output logic [15:0] s, output logic c,
                       output logic v);
    int sa;
    int sb;
    int sd;
    logic [16:0] full;
    sa = int'($signed(xa));
    sb = int'($signed(xb));
    if (xsub) begin
      s  = xa - xb;
      c  = (xa >= xb);
      sd = sa - sb;
    end else begin
      full = {1'b0, xa} + {1'b0, xb} + {16'h0, xcin};
      s  = full[15:0];
      c  = full[16];
      sd = sa + sb + (xcin ? 1 : 0);
    end
    v = (sd > 32767) || (sd < -32768);
  endtask

  task automatic do_op(input int d, input logic [15:0] xa, input logic [15:0] xb,
                       input logic xcin, input logic xsub, input string tag);
    logic [15:0] es;
    logic        ec;
    logic        ev;
    int          cnt;
    model(xa, xb, xcin, xsub, es, ec, ev);
    chk({tag, "_rdy"}, 32'(w_in_ready[d]), 32'd1);
    r_a = xa; r_b = xb; r_cin = xcin; r_sub = xsub;
    r_in_valid[d] = 1'b1;
    r_out_ready[d] = 1'b1;
    @(posedge clk); #1;
    r_in_valid[d] = 1'b0;
    // Scramble inputs during RUN; they must be ignored.
    r_a = 16'($urandom); r_b = 16'($urandom); r_cin = 1'($urandom); r_sub = 1'($urandom);
    chk({tag, "_hold"}, 32'(w_sum[d]), 32'(prev_sum[d]));
    cnt = 0;
    while (!w_out_valid[d] && cnt < 64) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_lat"}, 32'(cnt), 32'(nch[d]));
    chk({tag, "_sum"}, 32'(w_sum[d]), 32'(es));
    chk({tag, "_cout"}, 32'(w_cout[d]), 32'(ec));
    chk({tag, "_ovf"}, 32'(w_ovf[d]), 32'(ev));
    prev_sum[d] = es;
    @(posedge clk); #1;
    chk({tag, "_idle"}, 32'(w_in_ready[d]), 32'd1);
  endtask

  initial begin
    logic [15:0] es;
    logic        ec;
    logic        ev;
    #12;
    chk("rst_rdy", 32'(w_in_ready), 32'b111);
    chk("rst_val", 32'(w_out_valid), 32'b000);
    chk("rst_sum", 32'(w_sum[0]), 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    do_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, "add1");
    do_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "addwrap");
    do_op(0, 16'h7FFF, 16'h0000, 1'b1, 1'b0, "addovf");
    do_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, "sub1");
    do_op(0, 16'h8000, 16'h0001, 1'b1, 1'b1, "subovf");
    do_op(1, 16'h1234, 16'h4321, 1'b0, 1'b0, "n1add");
    do_op(2, 16'h1234, 16'h4321, 1'b0, 1'b0, "n16add");

    // Backpressure in DONE with in_valid pulsed.
    model(16'h0F0F, 16'h7070, 1'b1, 1'b0, es, ec, ev);
    r_a = 16'h0F0F; r_b = 16'h7070; r_cin = 1'b1; r_sub = 1'b0;
    r_in_valid[0] = 1'b1; r_out_ready[0] = 1'b0;
    @(posedge clk); #1;
    r_in_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
    chk("bp_enter", 32'(w_out_valid[0]), 32'd1);
    r_a = 16'hDEAD; r_b = 16'hBEEF; r_in_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_val", 32'(w_out_valid[0]), 32'd1);
      chk("bp_rdy", 32'(w_in_ready[0]), 32'd0);
      chk("bp_sum", 32'(w_sum[0]), 32'(es));
    end
    r_in_valid[0] = 1'b0;
    r_out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_val", 32'(w_out_valid[0]), 32'd0);
    chk("bp_rel_rdy", 32'(w_in_ready[0]), 32'd1);
    @(posedge clk); #1;
    chk("bp_noacc", 32'(w_in_ready[0]), 32'd1);
    chk("bp_keep", 32'(w_sum[0]), 32'(es));
    prev_sum[0] = es;

    // Asynchronous reset in the second RUN cycle.
    r_a = 16'hAAAA; r_b = 16'h5555; r_cin = 1'b0; r_sub = 1'b0;
    r_in_valid[0] = 1'b1;
    @(posedge clk); #1;
    r_in_valid[0] = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_rdy", 32'(w_in_ready[0]), 32'd1);
    chk("arst_val", 32'(w_out_valid[0]), 32'd0);
    chk("arst_sum", 32'(w_sum[0]), 32'h0);
    chk("arst_cout", 32'(w_cout[0]), 32'd0);
    chk("arst_ovf", 32'(w_ovf[0]), 32'd0);
    @(negedge clk); rst = 1'b0;
    prev_sum = '{16'h0, 16'h0, 16'h0};
    @(posedge clk); #1;
    do_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, "postrst");

    for (int i = 0; i < 30; i++) begin
      do_op(int'($urandom_range(0, 2)), 16'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom), "rnd");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
